spi_reg_ctrlr: RTL and testbench

// - Byte-oriented register controller behind an SPI slave; turns a 2-byte command/data

---
 rtl/spi_reg_ctrlr_pkg.sv | 38 +++
 rtl/spi_reg_ctrlr.sv | 78 +++++++
 tb/tb_spi_reg_ctrlr.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrlr_pkg.sv
// Shared definitions for the SPI register controller: FSM states, register
// addresses, command-byte layout and the register read mux.
package spi_reg_ctrlr_pkg;

    typedef enum logic {
        S_CMD  = 1'b0,
        S_DATA = 1'b1
    } state_e;

    localparam int unsigned RW_BIT    = 7;
    localparam int unsigned ADDR_W    = 7;

    localparam logic [ADDR_W-1:0] ADDR_CHIP_ID = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_SW_LO   = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_SW_HI   = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_LED_LO  = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_LED_HI  = 7'h04;

    // Register map read mux; unmapped addresses read as zero.
    function automatic logic [7:0] read_reg(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        chip_id,
        input logic [15:0]       sw,
        input logic [15:0]       led
    );
        logic [7:0] rdata;
        unique case (addr)
            ADDR_CHIP_ID: rdata = chip_id;
            ADDR_SW_LO:   rdata = sw[7:0];
            ADDR_SW_HI:   rdata = sw[15:8];
            ADDR_LED_LO:  rdata = led[7:0];
            ADDR_LED_HI:  rdata = led[15:8];
            default:      rdata = 8'h00;
        endcase
        return rdata;
    endfunction

endpackage

// File: rtl/spi_reg_ctrlr.sv
// Byte-oriented register controller behind an SPI slave. Each transaction is a
// CMD byte (bit7 = read, bits[6:0] = address) followed by a DATA byte. Reads
// present the register on dout right after the CMD byte so the SPI slave
// shifts it out during the DATA byte; writes commit the DATA byte to the LEDs.
module spi_reg_ctrlr
    import spi_reg_ctrlr_pkg::*;
#(
    parameter logic [7:0] CHIP_ID = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    input  logic        new_data,
    input  logic [7:0]  din,
    output logic [7:0]  dout
);

    state_e              state_q, state_d;
    logic                rw_q,    rw_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [15:0]         leds_q,  leds_d;
    logic [7:0]          dout_q,  dout_d;

    // Next-state logic: advance the CMD/DATA alternation on each received byte.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        leds_d  = leds_q;
        dout_d  = dout_q;

        if (new_data) begin
            unique case (state_q)
                S_CMD: begin
                    rw_d    = din[RW_BIT];
                    addr_d  = din[ADDR_W-1:0];
                    state_d = S_DATA;
                    // Reads sample switches/LEDs at the CMD edge; writes clear dout.
                    dout_d  = din[RW_BIT] ? read_reg(din[ADDR_W-1:0], CHIP_ID, switches, leds_q)
                                          : 8'h00;
                end
                S_DATA: begin
                    state_d = S_CMD;
                    // Only the LED bytes are writable; everything else is dropped.
                    if (!rw_q) begin
                        if (addr_q == ADDR_LED_LO) leds_d[7:0]  = din;
                        if (addr_q == ADDR_LED_HI) leds_d[15:8] = din;
                    end
                end
                default: state_d = S_CMD;
            endcase
        end
    end

    // State registers; async reset also discards any half-received transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CMD;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            leds_q  <= 16'h0000;
            dout_q  <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            leds_q  <= leds_d;
            dout_q  <= dout_d;
        end
    end

    assign leds = leds_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_spi_reg_ctrlr.sv
// Directed bench for spi_reg_ctrlr. Each transaction pushes the expected
// dout/leds into a scoreboard queue; the entry is popped and compared once the
// DATA byte has been accepted.
module tb_spi_reg_ctrlr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] switches = 16'h0000;
    logic [15:0] leds;
    logic        new_data = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;

    typedef struct packed {
        logic        is_read;
        logic [7:0]  dout;
        logic [15:0] leds;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_leds = 16'h0000;
    int          total = 0;
    int          bad   = 0;

    spi_reg_ctrlr #(.CHIP_ID(8'h07)) dut (
        .clk      (clk),
        .rst      (rst),
        .switches (switches),
        .leds     (leds),
        .new_data (new_data),
        .din      (din),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of a read, written from the register map description.
    function automatic logic [7:0] model_read(input logic [6:0] a);
        case (a)
            7'h00:   return 8'h07;
            7'h01:   return switches[7:0];
            7'h02:   return switches[15:8];
            7'h03:   return model_leds[7:0];
            7'h04:   return model_leds[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // One full transaction, CMD and DATA on back-to-back cycles.
    task automatic txn(input string tag, input logic [7:0] cmd, input logic [7:0] data);
        exp_t e;
        exp_t got;
        e.is_read = cmd[7];
        e.dout    = cmd[7] ? model_read(cmd[6:0]) : 8'h00;
        if (!cmd[7] && cmd[6:0] == 7'h03) model_leds[7:0]  = data;
        if (!cmd[7] && cmd[6:0] == 7'h04) model_leds[15:8] = data;
        e.leds = model_leds;
        sb_q.push_back(e);

        @(negedge clk);
        din = cmd; new_data = 1'b1;
        @(negedge clk);
        // Read data must already be on dout one clock after the CMD byte.
        if (cmd[7]) check({tag, "_cmd_dout"}, {8'h00, dout}, {8'h00, sb_q[0].dout});
        din = data;
        @(negedge clk);
        new_data = 1'b0;
        din = 8'h00;

        got = sb_q.pop_front();
        check({tag, "_dout"}, {8'h00, dout}, {8'h00, got.dout});
        check({tag, "_leds"}, leds, got.leds);
    endtask

    initial begin
        // Reset held for 10 clocks.
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_leds", leds, 16'h0000);
        check("rst_dout", {8'h00, dout}, 16'h0000);

        // Chip ID, twice.
        txn("chipid_a", 8'h80, 8'h00);
        txn("chipid_b", 8'h80, 8'h00);

        // Switch bytes.
        switches = 16'h00ff;
        txn("sw_lo", 8'h81, 8'h81);
        txn("sw_hi", 8'h82, 8'h82);
        switches = 16'hc35a;
        txn("sw_lo2", 8'h81, 8'h00);
        txn("sw_hi2", 8'h82, 8'h00);

        // LED write then readback.
        txn("led_wr_lo", 8'h03, 8'hff);
        check("led_wr_lo_abs", leds, 16'h00ff);
        txn("led_wr_hi", 8'h04, 8'haa);
        check("led_wr_hi_abs", leds, 16'haaff);
        txn("led_rd_lo", 8'h83, 8'h83);
        txn("led_rd_hi", 8'h84, 8'h84);

        // Clear, RO write ignored, unmapped read.
        txn("led_clr_lo", 8'h03, 8'h00);
        txn("led_clr_hi", 8'h04, 8'h00);
        check("led_clr_abs", leds, 16'h0000);
        txn("ro_write", 8'h01, 8'h55);
        txn("unmapped_wr", 8'h7f, 8'h66);
        txn("unmapped_rd", 8'h85, 8'h00);
        txn("chipid_c", 8'h80, 8'h00);

        // Async reset between CMD and DATA bytes.
        txn("pre_rst_wr", 8'h03, 8'h5a);
        @(negedge clk);
        din = 8'h04; new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
        #2 rst = 1'b1;
        #1 check("midrst_leds_async", leds, 16'h0000);
        @(negedge clk);
        #2 rst = 1'b0;
        model_leds = 16'h0000;
        @(negedge clk);
        check("midrst_leds", leds, 16'h0000);
        check("midrst_dout", {8'h00, dout}, 16'h0000);
        // Next byte must be taken as a CMD byte.
        txn("post_rst_chipid", 8'h80, 8'h12);
        txn("post_rst_led", 8'h84, 8'h00);

        check("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
